// File: rtl/image_proc.sv
// Bayer-to-gray converter feeding two SDRAM write ports, one gray pixel per 2x2 Bayer quad.
// Optional macro SOBEL_EN replaces the gray output with a saturated Sobel edge magnitude.
module image_proc #(
    parameter int          IMG_W_RAW = 1280,
    parameter int          IMG_H_RAW = 960,
    parameter int          ADDR_W    = 23,
    parameter logic [7:0]  WR_LEN    = 8'd128
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [11:0]       oDATA,
    input  logic [11:0]       oX_Cont,
    input  logic [15:0]       oY_Cont,
    input  logic [31:0]       oFrame_Cont,
    input  logic              oDVAL,
    output logic [15:0]       WR1_DATA,
    output logic              WR1,
    output logic [ADDR_W-1:0] WR1_ADDR,
    output logic [ADDR_W-1:0] WR1_MAX_ADDR,
    output logic [7:0]        WR1_LENGTH,
    output logic              WR1_LOAD,
    output logic              WR1_CLK,
    output logic [15:0]       WR2_DATA,
    output logic              WR2,
    output logic [ADDR_W-1:0] WR2_ADDR,
    output logic [ADDR_W-1:0] WR2_MAX_ADDR,
    output logic [7:0]        WR2_LENGTH,
    output logic              WR2_LOAD,
    output logic              WR2_CLK
);

    localparam logic [11:0] X_LIM = 12'(IMG_W_RAW);
    localparam logic [15:0] Y_LIM = 16'(IMG_H_RAW);

    function automatic logic [15:0] pack_hi(input logic [11:0] p);
        return {1'b0, p[11:7], p[11:2]};
    endfunction

    function automatic logic [15:0] pack_lo(input logic [11:0] p);
        return {1'b0, p[6:2], p[11:2]};
    endfunction

    logic [11:0] line_mem [0:IMG_W_RAW-1];
    logic [10:0] col_s;
    logic        beat_ok_s;
    logic        frame0_s;
    logic        quad_done_s;
    logic [11:0] line_rd_s;
    logic [13:0] sum_s;
    logic [11:0] gray_s;
    logic [11:0] p_s;
    logic        started_r;
    logic [11:0] g1_r;
    logic [11:0] b_r;
    logic        wr_r;
    logic [15:0] wr1_data_r;
    logic [15:0] wr2_data_r;
    logic        load_r;
    logic        unused_s;

    assign col_s       = oX_Cont[10:0];
    assign beat_ok_s   = oDVAL && (oX_Cont < X_LIM) && (oY_Cont < Y_LIM);
    assign frame0_s    = beat_ok_s && (oX_Cont == 12'd0) && (oY_Cont == 16'd0);
    assign quad_done_s = beat_ok_s && oY_Cont[0] && oX_Cont[0];
    assign line_rd_s   = line_mem[col_s];
    // On the odd/odd beat: G1 and B were latched earlier, R comes from the line buffer, G2 is live.
    assign sum_s       = {2'b00, g1_r} + {2'b00, line_rd_s} + {2'b00, b_r} + {2'b00, oDATA};
    assign gray_s      = sum_s[13:2];
    assign unused_s    = ^{oFrame_Cont, sum_s[1:0]};

`ifdef SOBEL_EN
    logic [11:0] lb_a [0:639];
    logic [11:0] lb_b [0:639];
    logic [9:0]  gx_s;
    logic [8:0]  gy_s;
    logic [11:0] top_s;
    logic [11:0] mid_s;
    logic [11:0] c1_t_r, c1_m_r, c1_b_r, c2_t_r, c2_m_r, c2_b_r;
    logic [15:0] right_s, left_s, bot_s, upper_s, ax_s, ay_s;
    logic [16:0] mag_s;

    assign gx_s  = oX_Cont[10:1];
    assign gy_s  = oY_Cont[9:1];
    assign top_s = lb_b[gx_s];
    assign mid_s = lb_a[gx_s];

    // Gray line buffers: the row above moves up, the new gray row lands below it.
    always_ff @(posedge clk) begin
        if (quad_done_s) begin
            lb_b[gx_s] <= mid_s;
            lb_a[gx_s] <= gray_s;
        end
    end

    // 3x3 window columns; column 0 is the live read, columns 1 and 2 are history.
    always_ff @(posedge clk) begin
        if (rst_n) begin
            c1_t_r <= 12'd0; c1_m_r <= 12'd0; c1_b_r <= 12'd0;
            c2_t_r <= 12'd0; c2_m_r <= 12'd0; c2_b_r <= 12'd0;
        end else if (quad_done_s) begin
            c2_t_r <= c1_t_r; c2_m_r <= c1_m_r; c2_b_r <= c1_b_r;
            c1_t_r <= top_s;  c1_m_r <= mid_s;  c1_b_r <= gray_s;
        end
    end

    // Sobel magnitude on unsigned partial sums, saturated to 12 bits, zero on the top/left border.
    always_comb begin
        right_s = {4'b0, top_s}  + {3'b0, mid_s, 1'b0}  + {4'b0, gray_s};
        left_s  = {4'b0, c2_t_r} + {3'b0, c2_m_r, 1'b0} + {4'b0, c2_b_r};
        bot_s   = {4'b0, c2_b_r} + {3'b0, c1_b_r, 1'b0} + {4'b0, gray_s};
        upper_s = {4'b0, c2_t_r} + {3'b0, c1_t_r, 1'b0} + {4'b0, top_s};
        if (right_s >= left_s) begin
            ax_s = right_s - left_s;
        end else begin
            ax_s = left_s - right_s;
        end
        if (bot_s >= upper_s) begin
            ay_s = bot_s - upper_s;
        end else begin
            ay_s = upper_s - bot_s;
        end
        mag_s = {1'b0, ax_s} + {1'b0, ay_s};
        if ((gx_s < 10'd2) || (gy_s < 9'd2)) begin
            p_s = 12'd0;
        end else if (mag_s > 17'd4095) begin
            p_s = 12'hFFF;
        end else begin
            p_s = mag_s[11:0];
        end
    end
`else
    assign p_s = gray_s;
`endif

    // Even-row line buffer; deliberately left out of reset.
    always_ff @(posedge clk) begin
        if (beat_ok_s && !oY_Cont[0]) begin
            line_mem[col_s] <= oDATA;
        end
    end

    // Frame-start gating, quad capture and the registered write port.
    always_ff @(posedge clk) begin
        if (rst_n) begin
            started_r  <= 1'b0;
            g1_r       <= 12'd0;
            b_r        <= 12'd0;
            wr_r       <= 1'b0;
            wr1_data_r <= 16'd0;
            wr2_data_r <= 16'd0;
            load_r     <= 1'b1;
        end else begin
            load_r <= 1'b0;
            if (frame0_s) begin
                started_r <= 1'b1;
            end
            if (beat_ok_s && oY_Cont[0] && !oX_Cont[0]) begin
                g1_r <= line_rd_s;
                b_r  <= oDATA;
            end
            if (quad_done_s && started_r) begin
                wr_r       <= 1'b1;
                wr1_data_r <= pack_hi(p_s);
                wr2_data_r <= pack_lo(p_s);
            end else begin
                wr_r <= 1'b0;
            end
        end
    end

    assign WR1          = wr_r;
    assign WR2          = wr_r;
    assign WR1_DATA     = wr1_data_r;
    assign WR2_DATA     = wr2_data_r;
    assign WR1_LOAD     = load_r;
    assign WR2_LOAD     = load_r;
    assign WR1_ADDR     = ADDR_W'(32'd0);
    assign WR1_MAX_ADDR = ADDR_W'(32'd307200);
    assign WR2_ADDR     = ADDR_W'(32'h0010_0000);
    assign WR2_MAX_ADDR = ADDR_W'(32'h0010_0000 + 32'd307200);
    assign WR1_LENGTH   = WR_LEN;
    assign WR2_LENGTH   = WR_LEN;
    assign WR1_CLK      = clk;
    assign WR2_CLK      = clk;

endmodule

// File: tb/tb_image_proc.sv
// Scoreboard bench for image_proc (default build): directed Bayer beats, queued expectations.
module tb_image_proc;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [11:0] oDATA;
    logic [11:0] oX_Cont;
    logic [15:0] oY_Cont;
    logic [31:0] oFrame_Cont;
    logic        oDVAL;
    logic [15:0] WR1_DATA, WR2_DATA;
    logic        WR1, WR2, WR1_LOAD, WR2_LOAD, WR1_CLK, WR2_CLK;
    logic [22:0] WR1_ADDR, WR1_MAX_ADDR, WR2_ADDR, WR2_MAX_ADDR;
    logic [7:0]  WR1_LENGTH, WR2_LENGTH;

    typedef struct {
        int          c;
        logic [11:0] p;
    } exp_t;

    exp_t sb[$];
    int   total = 0;
    int   bad = 0;
    int   cyc = 0;
    int   pulses = 0;
    int   exp_pulses = 0;

    always #5 clk = ~clk;

    image_proc dut (
        .clk(clk), .rst_n(rst_n), .oDATA(oDATA), .oX_Cont(oX_Cont), .oY_Cont(oY_Cont),
        .oFrame_Cont(oFrame_Cont), .oDVAL(oDVAL),
        .WR1_DATA(WR1_DATA), .WR1(WR1), .WR1_ADDR(WR1_ADDR), .WR1_MAX_ADDR(WR1_MAX_ADDR),
        .WR1_LENGTH(WR1_LENGTH), .WR1_LOAD(WR1_LOAD), .WR1_CLK(WR1_CLK),
        .WR2_DATA(WR2_DATA), .WR2(WR2), .WR2_ADDR(WR2_ADDR), .WR2_MAX_ADDR(WR2_MAX_ADDR),
        .WR2_LENGTH(WR2_LENGTH), .WR2_LOAD(WR2_LOAD), .WR2_CLK(WR2_CLK)
    );

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic logic [15:0] pk1(input logic [11:0] p);
        return {1'b0, p[11:7], p[11:2]};
    endfunction

    function automatic logic [15:0] pk2(input logic [11:0] p);
        return {1'b0, p[6:2], p[11:2]};
    endfunction

    // Monitor: every write pulse must match the oldest queued expectation in value and cycle.
    always @(negedge clk) begin
        exp_t e;
        if (sb.size() > 0 && sb[0].c < cyc) begin
            total++;
            bad++;
            $display("FAIL missed_output: no pulse at cycle %0d, still none at %0d", sb[0].c, cyc);
            void'(sb.pop_front());
        end
        if (WR1 || WR2) begin
            pulses++;
            if (sb.size() == 0) begin
                total++;
                bad++;
                $display("FAIL unexpected_output: pulse at cycle %0d data %h, none expected", cyc, WR1_DATA);
            end else begin
                e = sb.pop_front();
                chk("wr_latency", cyc, e.c);
                chk("wr1_data", {16'd0, WR1_DATA}, {16'd0, pk1(e.p)});
                chk("wr2_data", {16'd0, WR2_DATA}, {16'd0, pk2(e.p)});
                chk("wr_pair", {30'd0, WR1, WR2}, 32'd3);
            end
        end
    end

    task automatic beat(input int x, input int y, input logic [11:0] d, input logic v, input int ep);
        @(negedge clk);
        oX_Cont = 12'(x);
        oY_Cont = 16'(y);
        oDATA   = d;
        oDVAL   = v;
        if (ep >= 0) begin
            sb.push_back('{cyc + 1, 12'(ep)});
            exp_pulses++;
        end
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            oDVAL = 1'b0;
        end
    endtask

    task automatic quad(input int x0, input int y0, input logic [11:0] g1, input logic [11:0] r,
                        input logic [11:0] b, input logic [11:0] g2, input int ep);
        beat(x0, y0, g1, 1'b1, -1);
        beat(x0 + 1, y0, r, 1'b1, -1);
        beat(x0, y0 + 1, b, 1'b1, -1);
        beat(x0 + 1, y0 + 1, g2, 1'b1, ep);
    endtask

    // Two raw rows of a uniform value; optionally interleave invalid garbage beats.
    task automatic uni(input int y0, input int ncols, input logic [11:0] val, input bit tog, input bit ex);
        for (int yy = y0; yy < y0 + 2; yy++) begin
            for (int xx = 0; xx < ncols; xx++) begin
                if (tog) beat(xx, yy, ~val, 1'b0, -1);
                beat(xx, yy, val, 1'b1, (ex && (yy % 2 == 1) && (xx % 2 == 1)) ? int'(val) : -1);
            end
        end
    endtask

    initial begin
        rst_n = 1'b1; oDATA = 12'd0; oX_Cont = 12'd0; oY_Cont = 16'd0;
        oFrame_Cont = 32'd0; oDVAL = 1'b0;
        repeat (3) @(negedge clk);
        chk("reset_wr", {30'd0, WR1, WR2}, 32'd0);
        chk("reset_data", {WR1_DATA, WR2_DATA}, 32'd0);
        chk("reset_load", {30'd0, WR1_LOAD, WR2_LOAD}, 32'd3);
        chk("wr1_addr", {9'd0, WR1_ADDR}, 32'd0);
        chk("wr1_max", {9'd0, WR1_MAX_ADDR}, 32'd307200);
        chk("wr2_addr", {9'd0, WR2_ADDR}, 32'h0010_0000);
        chk("wr2_max", {9'd0, WR2_MAX_ADDR}, 32'h0014_B000);
        chk("wr_len", {16'd0, WR1_LENGTH, WR2_LENGTH}, 32'h0000_8080);
        rst_n = 1'b0;
        @(negedge clk);
        chk("load_release", {30'd0, WR1_LOAD, WR2_LOAD}, 32'd0);
        @(posedge clk);
        #1;
        chk("clk_high", {30'd0, WR1_CLK, WR2_CLK}, 32'd3);
        @(negedge clk);
        chk("clk_low", {30'd0, WR1_CLK, WR2_CLK}, 32'd0);

        // No frame start yet: complete quads must not produce writes.
        quad(4, 2, 12'd100, 12'd200, 12'd300, 12'd400, -1);
        uni(2, 4, 12'h800, 1'b0, 1'b0);
        idle(3);
        chk("no_pre_start", pulses, 0);

        // Frame start and uniform 12'h800 rows.
        uni(0, 32, 12'h800, 1'b0, 1'b1);
        idle(2);
        chk("uniform_count", pulses, 16);

        quad(0, 2, 12'd100, 12'd200, 12'd300, 12'd400, 250);
        quad(2, 2, 12'd1, 12'd1, 12'd1, 12'd0, 0);
        quad(4, 2, 12'hFFF, 12'hFFF, 12'hFFF, 12'hFFF, 4095);
        quad(6, 2, 12'hFFF, 12'hFFF, 12'hFFF, 12'hFFE, 4094);
        quad(8, 2, 12'h123, 12'h456, 12'h789, 12'hABC, 12'h5EF);

        // Invalid beats must neither write the line buffer nor emit a pixel.
        beat(10, 4, 12'd1000, 1'b1, -1);
        beat(11, 4, 12'd1000, 1'b1, -1);
        beat(10, 4, 12'd0, 1'b0, -1);
        beat(11, 4, 12'd0, 1'b0, -1);
        beat(10, 5, 12'd1000, 1'b1, -1);
        beat(11, 5, 12'd0, 1'b0, -1);
        beat(11, 5, 12'd1000, 1'b1, 1000);

        // Out-of-range coordinates, then the last in-range quad of the frame.
        beat(1281, 7, 12'd50, 1'b1, -1);
        beat(1, 961, 12'd50, 1'b1, -1);
        beat(1283, 961, 12'd50, 1'b1, -1);
        quad(1278, 958, 12'd8, 12'd8, 12'd8, 12'd8, 8);
        idle(2);
        chk("range_count", pulses, exp_pulses);

        uni(6, 16, 12'h800, 1'b1, 1'b1);

        // Reset in the middle of raw row 501 drops the qualifying beat and stops output.
        quad(0, 500, 12'd400, 12'd400, 12'd400, 12'd400, 400);
        beat(2, 500, 12'd400, 1'b1, -1);
        beat(3, 500, 12'd400, 1'b1, -1);
        beat(2, 501, 12'd400, 1'b1, -1);
        @(negedge clk);
        rst_n = 1'b1; oX_Cont = 12'd3; oY_Cont = 16'd501; oDATA = 12'd400; oDVAL = 1'b1;
        @(negedge clk);
        oDVAL = 1'b0;
        chk("midreset_load", {30'd0, WR1_LOAD, WR2_LOAD}, 32'd3);
        chk("midreset_wr", {30'd0, WR1, WR2}, 32'd0);
        chk("midreset_data", {WR1_DATA, WR2_DATA}, 32'd0);
        rst_n = 1'b0;
        uni(502, 8, 12'h800, 1'b0, 1'b0);
        idle(2);
        chk("no_output_after_reset", pulses, exp_pulses);
        uni(0, 8, 12'h400, 1'b0, 1'b1);

        idle(4);
        chk("pulse_count", pulses, exp_pulses);
        chk("scoreboard_empty", sb.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/image_proc.md
IMAGE_PROC -- requirements
Module: image_proc

Interface
REQ-001 Parameters SHALL be: IMG_W_RAW 1280 (raw Bayer columns); IMG_H_RAW 960 (raw Bayer rows); ADDR_W 23 (SDRAM address width); WR_LEN 8'd128 (burst length).
REQ-002 clk  input  1  sole clock; all logic on rising edge.
REQ-003 rst_n  input  1  reset, synchronous, active-high (asserted = 1, despite the suffix).
REQ-004 oDATA  input  12  raw Bayer pixel from capture block.
REQ-005 oX_Cont  input  12  raw column index; oY_Cont  input  16  raw row index; oFrame_Cont  input  32  frame count, unused except for debug.
REQ-006 oDVAL  input  1  pixel beat valid.
REQ-007 WR1_DATA / WR2_DATA  output  16  SDRAM write words, side 1 / side 2.
REQ-008 WR1 / WR2  output  1  write request, one pulse per output pixel.
REQ-009 WR1_ADDR, WR1_MAX_ADDR, WR2_ADDR, WR2_MAX_ADDR  output  ADDR_W  buffer start / end addresses.
REQ-010 WR1_LENGTH / WR2_LENGTH  output  8  burst length; WR1_LOAD / WR2_LOAD  output  1  FIFO clear; WR1_CLK / WR2_CLK  output  1  FIFO write clock.

Function
REQ-011 Constant outputs: WR1_ADDR=0, WR1_MAX_ADDR=307200, WR2_ADDR=0x100000, WR2_MAX_ADDR=0x100000+307200, WRx_LENGTH=WR_LEN, WRx_CLK=clk.
REQ-012 Bayer layout: even row = G1 (even x), R (odd x); odd row = B (even x), G2 (odd x).
REQ-013 One line buffer of IMG_W_RAW x 12 bits SHALL store the even row, indexed by oX_Cont, written on every oDVAL beat with oY_Cont[0]=0.
REQ-014 A gray pixel SHALL be produced on each oDVAL beat with oY_Cont[0]=1 and oX_Cont[0]=1: gray = (G1+R+B+G2) >> 2, summed at 14 bits; the result is 12 bits and is truncated, not rounded.
REQ-015 Output: 640x480 gray pixels per frame, raster order; valid one clk after the qualifying beat.
REQ-016 Packing: WR1_DATA={1'b0, p[11:7], p[11:2]}; WR2_DATA={1'b0, p[6:2], p[11:2]}; p = output pixel.
REQ-017 WR1 and WR2 SHALL be identical single-cycle pulses coincident with valid WRx_DATA; low otherwise.
REQ-018 oDVAL=0 beats SHALL be ignored, with no state change; beats with oX_Cont>=IMG_W_RAW or oY_Cont>=IMG_H_RAW SHALL be ignored.
REQ-019 After reset, WR1/WR2 SHALL stay low until the first oDVAL beat with oX_Cont=0 and oY_Cont=0 (frame start); from then on, output runs continuously.
REQ-020 Back-to-back valid beats every cycle SHALL be sustained, with no stall.

Reset
REQ-021 While rst_n=1: WR1=WR2=0; WR1_DATA=WR2_DATA=0; WR1_LOAD=WR2_LOAD=1; frame-start flag cleared; pipeline registers cleared.
REQ-022 WRx_LOAD SHALL deassert on the first clk after reset is released.
REQ-023 Line-buffer contents SHALL NOT be reset.
REQ-024 Reset mid-frame SHALL abort output; output resumes only per REQ-019.

Configuration
REQ-025 Macro SOBEL_EN: when it is undefined, p = gray.
REQ-026 With SOBEL_EN defined:
- Two 640x12 gray line buffers form a 3x3 window.
- p = min(|Gx|+|Gy|, 4095), Gx=[-1 0 1;-2 0 2;-1 0 1], Gy=Gx transposed.
- The output at gray position (x,y) is centered at (x-1,y-1).
- p=0 when x<2 or y<2.
- Pixel count and latency are unchanged from REQ-015.

Verification
REQ-027 Uniform raw frame 12'h800 -> 307200 WR1 pulses; every WR1_DATA=16'h4200, WR2_DATA=16'h0200.
REQ-028 Bayer quad G1=100, R=200, B=300, G2=400 -> p=250; WR1 one clk after the odd/odd beat.
REQ-029 oDVAL toggled 50% across a full frame -> still exactly 307200 WR1 pulses; values match the REQ-027 case.
REQ-030 rst_n pulsed at raw row 500 -> WRx_LOAD=1 during reset; no WR1 until the next (0,0) beat; next frame then yields 307200 pulses.
REQ-031 SOBEL_EN, uniform frame -> all p=0; vertical step from gray 0 to 4095 -> p=4095 (saturated) along the edge columns, 0 elsewhere.
